ifu_prefetch: RTL and testbench
===============================

// Module: ifu_prefetch
// PURPOSE
//   Next-generation instruction fetch unit. Replaces the combinational DPI fetch with a
//   request/response memory port and a parametrised prefetch FIFO of {pc,instr} pairs.
//   Sits between instruction memory and IDU; EXU redirects it on taken branches/jumps.
//   Decouples memory latency from decode; delivers instructions to IDU in a valid/ready handshake.
// PARAMETERS
//   XLEN        32             address/instruction width
//   RESET_PC    32'h8000_0000  first fetch address after reset
//   DEPTH       4              prefetch FIFO entries; power of two, >= 2
// PORTS
//   clk            in   1     clock, all state on rising edge
//   rst            in   1     reset, synchronous, active-high
//   mem_req_valid  out  1     fetch request valid
//   mem_req_ready  in   1     memory accepts request
//   mem_req_addr   out  XLEN  word-aligned fetch address
//   mem_rsp_valid  in   1     response data valid (memory always ready for rsp)
//   mem_rsp_data   in   XLEN  fetched instruction
//   redirect_valid in   1     EXU taken branch/jump this cycle
//   redirect_pc    in   XLEN  new fetch PC; bits [1:0] ignored (forced 0)
//   out_valid      out  1     instruction available to IDU
//   out_ready      in   1     IDU accepts instruction
//   out_pc         out  XLEN  PC of head instruction
//   out_instr      out  XLEN  head instruction
//   out_ebreak     out  1     out_valid && out_instr==32'h0010_0073
// BEHAVIOUR
//   Reset: fetch_pc=RESET_PC, state=IDLE, FIFO empty, kill=0; mem_req_valid=0, out_valid=0,
//     out_ebreak=0. rst dominates all other inputs, including mid-transaction (response dropped).
//   FSM (one outstanding request max):
//     IDLE: if (count + 0) < DEPTH and !redirect_valid -> REQ (issue next cycle). Else stay.
//     REQ : mem_req_valid=1, mem_req_addr=fetch_pc, both held stable until mem_req_ready.
//           On handshake: fetch_pc += 4 (wraps mod 2^XLEN); -> WAIT, or -> DROP if kill.
//     WAIT: on mem_rsp_valid push {issued_pc, mem_rsp_data}; -> IDLE. Earliest rsp: cycle
//           after request handshake.
//     DROP: on mem_rsp_valid discard data; kill=0; -> IDLE.
//   Space: request issued only if count + 1 <= DEPTH counting the in-flight slot, so a
//     response is never blocked; FIFO overflow is impossible by construction.
//   Redirect (priority over all pushes/pops in same cycle):
//     FIFO flushed (count=0); pop that cycle ignored; out_valid forced 0 that cycle.
//     fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
//     IDLE -> stay IDLE (request next cycle from new PC). WAIT -> DROP.
//     WAIT with mem_rsp_valid same cycle -> response discarded, -> IDLE.
//     REQ: request not withdrawn; kill=1; on handshake -> DROP; fetch_pc keeps redirect
//       target (no +4). Redirect during DROP: fetch_pc updated, stays DROP.
//   Output: out_valid = (count!=0) && !redirect_valid; out_pc/out_instr from head (registered
//     FIFO storage, no comb path mem_rsp -> out). Pop on out_valid && out_ready.
//   Simultaneous push+pop: count unchanged, both performed. Pointers wrap mod DEPTH.
//   Latency: reset -> first out_valid >= 3 cycles (IDLE,REQ,WAIT+push) with 0-wait memory;
//     redirect -> first out_valid of target >= 3 cycles.
//   Throughput: max one instr per 3 cycles (single outstanding request).
//   ebreak: out_ebreak is combinational flag only; sim stop handled by the TB/DPI wrapper.
// TESTING
//   1 Reset, zero-wait memory returning addr as data -> out_pc 8000_0000,8000_0004,... in
//     order, out_instr==out_pc, no gaps/duplicates.
//   2 out_ready=0 for 20 cycles -> count saturates at DEPTH, mem_req_valid stays 0, no
//     entry lost; release -> DEPTH instrs drained in order.
//   3 redirect_valid with redirect_pc=8000_0103 while WAIT -> stale rsp discarded, next
//     out_pc=8000_0100.
//   4 redirect during REQ with mem_req_ready low 3 cycles -> mem_req_addr stable, response
//     dropped, next request addr = redirect target.
//   5 redirect same cycle as mem_rsp_valid and out_valid&&out_ready -> FIFO empty next
//     cycle, no pop counted, no push.
//   6 Memory returns 32'h0010_0073 -> out_ebreak=1 exactly while that entry is head and
//     valid; rst asserted mid-WAIT -> outputs at reset values next cycle.

Source files
------------

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: single-outstanding request/response memory port feeding a
// DEPTH-entry prefetch FIFO of {pc,instr} pairs toward decode, with EXU redirect/flush.
module ifu_prefetch #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000,
  parameter int               DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_data_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_instr_o,
  output logic            out_ebreak_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] EBREAK = XLEN'(32'h0010_0073);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic [XLEN-1:0]   req_addr_q;
  logic              req_valid_q;
  logic              kill_q;

  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [XLEN-1:0]   instr_mem[DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic [XLEN-1:0]   redir_pc;
  logic              req_hs;
  logic              push;
  logic              pop;

  assign redir_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign req_hs   = req_valid_q && mem_req_ready_i;
  assign push     = (state_q == S_WAIT) && mem_rsp_valid_i && !redirect_valid_i;
  assign pop      = out_valid_o && out_ready_i;

  // req_addr_q is latched on entry to REQ so the address stays stable even if a
  // redirect moves fetch_pc_q while the request is still waiting for ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_valid_i) begin
            fetch_pc_q <= redir_pc;
          end else if (count_q < CW'(DEPTH)) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= fetch_pc_q;
          end
        end
        S_REQ: begin
          if (redirect_valid_i) begin
            fetch_pc_q <= redir_pc;
            kill_q     <= 1'b1;
          end
          if (req_hs) begin
            req_valid_q <= 1'b0;
            if (redirect_valid_i || kill_q) begin
              state_q <= S_DROP;
            end else begin
              state_q    <= S_WAIT;
              fetch_pc_q <= fetch_pc_q + XLEN'(4);
            end
          end
        end
        S_WAIT: begin
          if (redirect_valid_i) fetch_pc_q <= redir_pc;
          if (mem_rsp_valid_i) begin
            state_q <= S_IDLE;
          end else if (redirect_valid_i) begin
            state_q <= S_DROP;
            kill_q  <= 1'b1;
          end
        end
        default: begin
          if (redirect_valid_i) fetch_pc_q <= redir_pc;
          if (mem_rsp_valid_i) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_addr_q;
      instr_mem[wr_ptr_q] <= mem_rsp_data_i;
    end
  end

  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = req_addr_q;
  assign out_valid_o     = (count_q != '0) && !redirect_valid_i;
  assign out_pc_o        = pc_mem[rd_ptr_q];
  assign out_instr_o     = instr_mem[rd_ptr_q];
  assign out_ebreak_o    = out_valid_o && (out_instr_o == EBREAK);

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: memory model answers each accepted request with its address
// (or ebreak at one chosen address); a scoreboard queue predicts the IDU stream.
module tb_ifu_prefetch;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ebreak;

  always #5 clk = ~clk;

  ifu_prefetch #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o(mem_req_addr),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_instr_o(out_instr), .out_ebreak_o(out_ebreak)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // stimulus-controlled memory knobs
  bit          ready_en  = 1'b1;
  int          lat       = 0;
  logic [31:0] ebrk_addr = 32'hFFFF_FFF0;

  // model state (owned by the model process)
  bit          pend     = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  logic [63:0] sb_q[$];
  logic [31:0] nxt_pc = RST_PC;
  int          npop   = 0;
  int          nebrk  = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == ebrk_addr) ? EBRK : a;
  endfunction

  always begin
    logic [63:0] e;
    @(posedge clk);
    if (rst) begin
      sb_q.delete();
      nxt_pc = RST_PC;
      pend   = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_pop", out_valid, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("out_pc", out_pc, e[63:32]);
          chk("out_instr", out_instr, e[31:0]);
          chk("out_ebreak", out_ebreak, e[31:0] == EBRK);
          npop++;
          if (e[31:0] == EBRK) nebrk++;
        end
      end
      if (redirect_valid) chk("rdr_no_valid", out_valid, 1'b0);
      if (mem_req_valid && mem_req_ready) begin
        pend      = 1'b1;
        pend_cnt  = lat;
        pend_data = mem_data(mem_req_addr);
        if (!redirect_valid && mem_req_addr == nxt_pc) begin
          sb_q.push_back({mem_req_addr, mem_data(mem_req_addr)});
          nxt_pc += 32'd4;
        end
      end
      if (redirect_valid) begin
        sb_q.delete();
        nxt_pc = {redirect_pc[31:2], 2'b00};
      end
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    if (!rst && pend) begin
      if (pend_cnt == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pend_data;
        pend          = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    mem_req_ready = ready_en;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 60) begin step(); n++; end
    if (!out_valid) chk({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic wait_pend(input string tag);
    int n = 0;
    while (!pend && n < 60) begin step(); n++; end
    if (!pend) chk({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic wait_pops(input int target, input string tag);
    int n = 0;
    while (npop < target && n < 200) begin step(); n++; end
    chk({tag, "_pops"}, npop >= target, 1'b1);
  endtask

  initial begin
    int cyc;
    int p0;
    logic [31:0] a;

    repeat (3) step();
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ebreak", out_ebreak, 1'b0);
    rst = 1'b0;

    // 1: in-order stream from reset
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    chk("first_valid", out_valid, 1'b1);
    chk("lat_ge3", cyc >= 3, 1'b1);
    chk("first_pc", out_pc, RST_PC);
    wait_pops(8, "t1");

    // 2: decode stall fills FIFO, then drains
    out_ready = 1'b0;
    repeat (20) step();
    chk("stall_noreq", mem_req_valid, 1'b0);
    chk("stall_full", sb_q.size(), DEPTH);
    chk("stall_valid", out_valid, 1'b1);
    p0 = npop;
    out_ready = 1'b1;
    wait_pops(p0 + DEPTH, "t2");

    // 3: redirect while waiting on memory
    lat = 3;
    wait_pend("t3");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    step();
    redirect_valid = 1'b0;
    lat = 0;
    wait_valid("t3");
    chk("redir_wait_pc", out_pc, 32'h8000_0100);
    wait_pops(npop + 4, "t3");

    // 4: redirect while request held off by memory
    ready_en = 1'b0;
    cyc = 0;
    while (!(mem_req_valid && !mem_req_ready) && cyc < 60) begin step(); cyc++; end
    chk("t4_req_pending", mem_req_valid && !mem_req_ready, 1'b1);
    a = mem_req_addr;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("req_addr_hold", mem_req_addr, a);
      chk("req_valid_hold", mem_req_valid, 1'b1);
      step();
    end
    ready_en = 1'b1;
    wait_valid("t4");
    chk("redir_req_pc", out_pc, 32'h8000_0200);
    wait_pops(npop + 4, "t4");

    // 5: redirect coinciding with response and pop
    out_ready = 1'b0;
    repeat (15) step();
    out_ready = 1'b1;
    cyc = 0;
    while (!(mem_rsp_valid && out_valid) && cyc < 60) begin step(); cyc++; end
    chk("t5_coincide", mem_rsp_valid && out_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    p0 = npop;
    step();
    redirect_valid = 1'b0;
    chk("flush_empty", out_valid, 1'b0);
    chk("flush_nopop", npop, p0);
    wait_valid("t5");
    chk("flush_next_pc", out_pc, 32'h8000_0400);

    // 6: ebreak flag, then reset while waiting on memory
    ebrk_addr      = 32'h8000_0508;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0500;
    step();
    redirect_valid = 1'b0;
    wait_pops(npop + 5, "t6");
    chk("ebreak_seen", nebrk, 1);
    lat = 3;
    wait_pend("t6");
    rst = 1'b1;
    step();
    chk("mid_rst_req_valid", mem_req_valid, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_ebreak", out_ebreak, 1'b0);
    lat = 0;
    rst = 1'b0;
    wait_valid("t6");
    chk("post_rst_pc", out_pc, RST_PC);
    wait_pops(npop + 3, "t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
